// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: command/state encodings, PID and SYNC bytes, CRC-16/USB constants
package usb_tx_pkg;
  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_DATA0 = 3'd1,
    CMD_DATA1 = 3'd2,
    CMD_ACK   = 3'd3,
    CMD_NAK   = 3'd4,
    CMD_STALL = 3'd5
  } tx_cmd_t;
  typedef enum logic [3:0] {IDLE, SYNC, PID, FETCH, DATA, CRC_LO, CRC_HI, EOP, ERROR} state_t;
  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK = 8'hD2;
  localparam logic [7:0] PID_NAK = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  function automatic logic [7:0] pid_byte(input tx_cmd_t c);
    return c == CMD_DATA0 ? PID_DATA0 : c == CMD_DATA1 ? PID_DATA1 :
           c == CMD_ACK ? PID_ACK : c == CMD_NAK ? PID_NAK : PID_STALL;
  endfunction
endpackage

// File: rtl/usb_tx_packet_sequencer_crc16.sv
// usb_crc16: registered CRC-16/USB accumulator, one byte folded in per update, LSB first
module usb_crc16
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        update,
  input  logic [7:0]  data,
  output logic [15:0] crc
);
  function automatic logic [15:0] crc_next(input logic [15:0] c, input logic [7:0] d);
    for (int i = 0; i < 8; i++) c = (c >> 1) ^ ((c[0] ^ d[i]) ? CRC16_POLY_REFL : 16'h0000);
    return c;
  endfunction
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) crc <= CRC16_INIT;
    else if (clear) crc <= CRC16_INIT;
    else if (update) crc <= crc_next(crc, data);
endmodule

// File: rtl/usb_tx_packet_sequencer.sv
// usb_tx_packet_sequencer: emits SYNC, PID, payload, CRC16 and EOP per TX command.
// Defining TX_TIMEOUT_EN adds a serializer/EOP stall timeout that aborts to ERROR.
module usb_tx_packet_sequencer
  import usb_tx_pkg::*;
#(
  parameter int MAX_PACKET_BYTES = 64
`ifdef TX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] tx_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  output logic       get_tx_packet_data,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       eop_req,
  input  logic       eop_done,
  output logic       tx_transfer_active,
  output logic       tx_error
);
  state_t state, nxt;
  tx_cmd_t cmd;
  logic armed, start, bad, fresh, upd;
  logic [6:0] cnt;
  logic [7:0] data_q, cur;
  logic [15:0] crc;
  assign start = state == IDLE && armed && tx_packet != 3'd0;
  assign bad = tx_packet > 3'd5 ||
               ((tx_packet == 3'd1 || tx_packet == 3'd2) && 32'(buffer_occupancy) > MAX_PACKET_BYTES);
  // buffer data arrives in the first DATA cycle; afterwards the captured copy is held
  assign cur = fresh ? tx_packet_data : data_q;
  assign byte_valid = state inside {SYNC, PID, DATA, CRC_LO, CRC_HI};
  assign get_tx_packet_data = state == FETCH;
  assign eop_req = state == EOP;
  assign tx_error = state == ERROR;
  assign tx_transfer_active = state != IDLE && state != ERROR;
  assign upd = state == DATA && byte_ready;
  assign byte_out = state == SYNC ? SYNC_BYTE : state == PID ? pid_byte(cmd) :
                    state == DATA ? cur : state == CRC_LO ? ~crc[7:0] :
                    state == CRC_HI ? ~crc[15:8] : 8'h00;
`ifdef TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo;
  logic stall, tmo_hit;
  assign stall = (byte_valid && !byte_ready) || (eop_req && !eop_done);
  assign tmo_hit = stall && 32'(tmo) == TIMEOUT_CYCLES - 1;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) tmo <= '0;
    else tmo <= (stall && state != IDLE) ? tmo + TW'(1) : '0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:   nxt = start ? (bad ? ERROR : SYNC) : IDLE;
      SYNC:   nxt = byte_ready ? PID : SYNC;
      PID:    if (byte_ready) nxt = cmd inside {CMD_ACK, CMD_NAK, CMD_STALL} ? EOP :
                                    cnt == 7'd0 ? CRC_LO : FETCH;
      FETCH:  nxt = DATA;
      DATA:   if (byte_ready) nxt = cnt == 7'd1 ? CRC_LO : FETCH;
      CRC_LO: nxt = byte_ready ? CRC_HI : CRC_LO;
      CRC_HI: nxt = byte_ready ? EOP : CRC_HI;
      EOP:    nxt = eop_done ? IDLE : EOP;
      default: nxt = IDLE;
    endcase
`ifdef TX_TIMEOUT_EN
    if (tmo_hit) nxt = ERROR;
`endif
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else state <= nxt;
  // armed blocks a relaunch until the slave's command register reads back 0
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      armed <= 1'b1;
      cmd <= CMD_NONE;
      cnt <= 7'd0;
      data_q <= 8'h00;
      fresh <= 1'b0;
    end else begin
      armed <= start ? 1'b0 : (state == IDLE && tx_packet == 3'd0) ? 1'b1 : armed;
      fresh <= state == FETCH;
      if (state == DATA) data_q <= cur;
      if (start) begin
        cmd <= tx_cmd_t'(tx_packet);
        cnt <= buffer_occupancy;
      end else if (upd) cnt <= cnt - 7'd1;
    end
  usb_crc16 u_crc (
    .clk(clk),
    .n_rst(n_rst),
    .clear(nxt == IDLE),
    .update(upd),
    .data(cur),
    .crc(crc)
  );
endmodule

// File: tb/tb_usb_tx_packet_sequencer.sv
// tb_usb_tx_packet_sequencer: randomized packets checked against a byte-stream model of the packet rules
module tb_usb_tx_packet_sequencer;
  logic clk = 0, n_rst = 0;
  logic [2:0] tx_packet = 0;
  logic [6:0] buffer_occupancy = 0;
  logic [7:0] tx_packet_data = 0;
  logic get_tx_packet_data, byte_valid, eop_req, tx_transfer_active, tx_error;
  logic [7:0] byte_out;
  logic byte_ready = 1, eop_done = 0;
  int checks = 0, failures = 0;
  int rmode = 0, stop_at = 0;
  int n_eop = 0, n_err = 0, n_pop = 0, n_act = 0, n_bvc = 0, n_unstable = 0, n_viol = 0;
  logic [7:0] rx[$];
  logic [7:0] mem[0:16383];
  logic pv = 0, pr = 0;
  logic [7:0] pb = 0;

  always #5 clk = ~clk;

  usb_tx_packet_sequencer dut (
    .clk(clk), .n_rst(n_rst), .tx_packet(tx_packet), .buffer_occupancy(buffer_occupancy),
    .tx_packet_data(tx_packet_data), .get_tx_packet_data(get_tx_packet_data),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .eop_req(eop_req), .eop_done(eop_done), .tx_transfer_active(tx_transfer_active),
    .tx_error(tx_error)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] crc16(input logic [7:0] q[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (q[k])
      for (int i = 0; i < 8; i++) begin
        logic fb = c[0] ^ q[k][i];
        c = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    return c;
  endfunction

  function automatic logic [7:0] pid(input logic [2:0] c);
    case (c)
      3'd1: return 8'hC3;
      3'd2: return 8'h4B;
      3'd3: return 8'hD2;
      3'd4: return 8'h5A;
      default: return 8'h1E;
    endcase
  endfunction

  always @(negedge clk)
    if (!n_rst) pv = 0;
    else begin
      if (pv && !pr && (!byte_valid || byte_out !== pb)) n_unstable++;
      if (byte_valid && byte_ready) rx.push_back(byte_out);
      if (eop_req && eop_done) n_eop++;
      if (tx_error) n_err++;
      if (tx_transfer_active) n_act++;
      if (byte_valid) n_bvc++;
      if ((byte_valid || eop_req || get_tx_packet_data) && !tx_transfer_active) n_viol++;
      if (tx_error && tx_transfer_active) n_viol++;
      pv = byte_valid; pr = byte_ready; pb = byte_out;
    end

  always @(negedge clk)
    if (n_rst && get_tx_packet_data) begin
      @(posedge clk);
      #1 tx_packet_data = mem[n_pop];
      n_pop++;
    end

  always @(posedge clk) begin
    #1;
    byte_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom % 2) : 1'(rx.size() < stop_at);
    eop_done = eop_req ? (!eop_done && $urandom % 3 == 0) : ($urandom % 16 == 0);
  end

  task automatic run(input logic [2:0] c, input int occ, input int mode, input int hold,
                     input bit fixed, input bit tmo);
    logic [7:0] d[$];
    logic [7:0] ex[$];
    logic [15:0] cr;
    int b, e0, r0, g0, a0, v0, i;
    bit isdata, ok;
    isdata = c == 3'd1 || c == 3'd2;
    ok = c >= 3'd1 && c <= 3'd5 && !(isdata && occ > 64) && !tmo;
    g0 = n_pop;
    for (int k = 0; k < occ; k++) begin
      d.push_back(fixed ? 8'(8'h31 + k) : 8'($urandom));
      mem[g0 + k] = d[k];
    end
    if (ok) begin
      ex = {8'h80, pid(c)};
      if (isdata) begin
        foreach (d[k]) ex.push_back(d[k]);
        cr = crc16(d);
        ex.push_back(~cr[7:0]);
        ex.push_back(~cr[15:8]);
      end
    end else if (tmo) ex = {8'h80};
    b = rx.size(); e0 = n_eop; r0 = n_err; a0 = n_act; v0 = n_bvc; stop_at = b + 1;
    @(posedge clk);
    #1 tx_packet = c; buffer_occupancy = 7'(occ); rmode = mode;
    for (i = 0; i < 4000 && n_eop == e0 && n_err == r0; i++) begin
      @(negedge clk);
      #1;
    end
    check("done_in_time", i < 4000, 1);
    repeat (hold) @(posedge clk);
    @(posedge clk);
    #1 tx_packet = 0; buffer_occupancy = 7'($urandom); rmode = 0;
    repeat (3) @(negedge clk);
    #1;
    check($sformatf("len_cmd%0d_occ%0d", c, occ), rx.size() - b, ex.size());
    for (int k = 0; k < ex.size() && b + k < rx.size(); k++)
      check($sformatf("byte%0d_cmd%0d", k, c), rx[b + k], ex[k]);
    check("err_pulses", n_err - r0, ok ? 0 : 1);
    check("eop_count", n_eop - e0, ok ? 1 : 0);
    check("get_pulses", n_pop - g0, (ok && isdata) ? occ : 0);
    check("active_after", tx_transfer_active, 0);
    if (!ok && !tmo) begin
      check("err_active_cycles", n_act - a0, 0);
      check("err_valid_cycles", n_bvc - v0, 0);
    end
    if (tmo) check("tmo_valid_cycles", n_bvc - v0, 256);
    if (fixed && occ == 9 && rx.size() - b == 13) begin
      check("crc_lo_known", rx[b + 11], 8'hC8);
      check("crc_hi_known", rx[b + 12], 8'hB4);
    end
  endtask

  initial begin
    int b, g0, i;
    repeat (3) @(negedge clk);
    check("rst_valid", byte_valid, 0);
    check("rst_byte", byte_out, 0);
    check("rst_get", get_tx_packet_data, 0);
    check("rst_eop", eop_req, 0);
    check("rst_active", tx_transfer_active, 0);
    check("rst_err", tx_error, 0);
    @(posedge clk);
    #1 n_rst = 1;
    repeat (2) @(negedge clk);
    run(3'd3, 5, 0, 0, 0, 0);
    run(3'd2, 0, 0, 0, 0, 0);
    run(3'd1, 9, 0, 0, 1, 0);
    run(3'd1, 9, 1, 0, 1, 0);
    run(3'd6, 0, 0, 0, 0, 0);
    run(3'd7, 3, 0, 0, 0, 0);
    run(3'd1, 65, 0, 0, 0, 0);
    run(3'd2, 64, 1, 0, 0, 0);
    run(3'd4, 0, 0, 10, 0, 0);
    run(3'd4, 0, 1, 0, 0, 0);
    run(3'd5, 0, 1, 0, 0, 0);
    g0 = n_pop;
    for (int k = 0; k < 9; k++) mem[g0 + k] = 8'(8'h31 + k);
    b = rx.size();
    @(posedge clk);
    #1 tx_packet = 1; buffer_occupancy = 9; rmode = 1;
    for (i = 0; i < 2000 && rx.size() - b < 4; i++) begin
      @(negedge clk);
      #1;
    end
    check("rst_reach_data", i < 2000, 1);
    #2 n_rst = 0;
    #1;
    check("amid_valid", byte_valid, 0);
    check("amid_byte", byte_out, 0);
    check("amid_get", get_tx_packet_data, 0);
    check("amid_eop", eop_req, 0);
    check("amid_active", tx_transfer_active, 0);
    check("amid_err", tx_error, 0);
    tx_packet = 0; rmode = 0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1;
    repeat (3) @(negedge clk);
    run(3'd1, 9, 1, 0, 1, 0);
    for (int k = 0; k < 25; k++)
      run(3'($urandom_range(1, 7)),
          ($urandom % 8 == 0) ? $urandom_range(65, 127) : $urandom_range(0, 64),
          $urandom_range(0, 1), $urandom_range(0, 3), 0, 0);
`ifdef TX_TIMEOUT_EN
    run(3'd4, 0, 2, 0, 0, 1);
`endif
    check("byte_stable", n_unstable, 0);
    check("active_consistency", n_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/usb_tx_packet_sequencer.md
Name: usb_tx_packet_sequencer

Overview:
- Sequences one USB transmit packet per command from the AHB slave's TX control register (tx_packet).
- Emits SYNC, PID, the payload bytes pulled from the TX data buffer, CRC16 and EOP to the downstream bit serializer over a byte-level valid/ready handshake.
- Drives tx_transfer_active and tx_error back to the AHB slave's status and error registers.

Parameters:
- MAX_PACKET_BYTES, 64: largest payload accepted; a larger occupancy at start is an error.
- TIMEOUT_CYCLES, 255: serializer stall limit; used only when TX_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- tx_packet  in  3  command: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, 6/7 illegal
- buffer_occupancy  in  7  bytes held in the TX data buffer
- tx_packet_data  in  8  buffer read data, valid the cycle after get_tx_packet_data
- get_tx_packet_data  out  1  one-cycle buffer pop strobe
- byte_out  out  8  byte to serializer
- byte_valid  out  1  byte_out is valid
- byte_ready  in  1  serializer accepts byte_out when byte_valid && byte_ready
- eop_req  out  1  request EOP signalling
- eop_done  in  1  one-cycle pulse: EOP finished
- tx_transfer_active  out  1  packet in progress
- tx_error  out  1  one-cycle error pulse

Behaviour:
- Reset (asynchronous, any state, including mid-packet): state IDLE, armed=1, crc=16'hFFFF, all outputs 0, byte counter 0.
- Start: in IDLE with armed=1 and tx_packet!=0. On start, clear armed and latch cmd and buffer_occupancy into the 7-bit counter. In IDLE, set armed=1 whenever tx_packet==0. This blocks re-launch while the slave's stale register value clears.
- Illegal cmd (6/7), or DATA cmd with occupancy>MAX_PACKET_BYTES: go to ERROR. Nothing is sent to the serializer.
- States: IDLE, SYNC, PID, FETCH, DATA, CRC_LO, CRC_HI, EOP, ERROR.
- SYNC: byte_out=8'h80, byte_valid=1. On handshake -> PID.
- PID: byte_out = C3 (DATA0), 4B (DATA1), D2 (ACK), 5A (NAK), 1E (STALL).
  - On handshake, handshake cmds (ACK/NAK/STALL) -> EOP.
  - DATA cmds with counter==0 -> CRC_LO.
  - Otherwise -> FETCH.
- FETCH: get_tx_packet_data=1 for exactly this cycle -> DATA.
- DATA: byte_out=tx_packet_data, registered on entry and held stable while waiting. On handshake, decrement counter and fold the byte into crc, then -> FETCH if counter now !=0, else CRC_LO.
- CRC (CRC-16/USB):
  - init FFFF; per bit LSB first: fb=crc[0]^d; crc>>=1; if fb, crc^=A001.
  - CRC_LO sends ~crc[7:0], then CRC_HI sends ~crc[15:8], then EOP.
- EOP: eop_req=1 until eop_done, then -> IDLE. Reinitialise crc to FFFF on entering IDLE.
- ERROR: tx_error=1 for one cycle -> IDLE.
- tx_transfer_active: 1 in every state except IDLE and ERROR. Drops in the cycle after eop_done.
- byte_valid: 1 only in SYNC, PID, DATA, CRC_LO, CRC_HI. byte_out holds its value until the handshake.
- Latency: start to first byte_valid is 1 cycle. Each payload byte costs at least 2 cycles (FETCH + DATA).
- tx_packet and buffer_occupancy changes are ignored while the block is not in IDLE.
- eop_done outside EOP is ignored.
- byte_ready while byte_valid=0 is ignored.

Optional Feature:
- Macro TX_TIMEOUT_EN.
- Defined: a counter runs while byte_valid&&!byte_ready or eop_req&&!eop_done, and resets on any handshake.
  - Reaching TIMEOUT_CYCLES -> ERROR: tx_error pulse, tx_transfer_active drops, no EOP.
  - Remaining payload is not popped from the buffer; the AHB flush register clears it.
- Undefined: the block waits indefinitely. No counter logic exists.

Decomposition:
- Package usb_tx_pkg: tx_packet command enum, PID byte constants, SYNC_BYTE, the state enum, CRC16_INIT and CRC16_POLY_REFL.
- Sub-module usb_crc16: byte-wise combinational next-CRC function with a registered crc value. Ports: clk, n_rst, clear, update, data[7:0], crc[15:0].

Test Plan:
- tx_packet=3 (ACK), byte_ready tied 1 -> bytes 80, D2; then eop_req until eop_done; tx_transfer_active high throughout; no get_tx_packet_data pulses.
- tx_packet=2, occupancy=0 -> bytes 80, 4B, 00, 00; then EOP (zero-length DATA1).
- tx_packet=1, occupancy=9, buffer holds 31..39 -> bytes 80, C3, 31..39, C8, B4; exactly 9 get pulses; byte_ready randomly throttled gives the same byte stream.
- tx_packet=6, and separately DATA with occupancy=65 -> single tx_error pulse; tx_transfer_active stays 0; byte_valid never rises.
- tx_packet held at 4 for 10 cycles after EOP -> only one NAK sent; a new NAK is sent only after tx_packet returns to 0 and is set to 4 again.
- n_rst asserted during DATA with byte 3 of 9 outstanding -> all outputs 0 immediately; after release, state IDLE and a new DATA0 command starts with crc=FFFF.
- With TX_TIMEOUT_EN defined: byte_ready held 0 in PID for 255 cycles -> tx_error pulse; no eop_req.
